// File: rtl/cursor_move_ctrl_pkg.sv
// Shared constants for the keyboard cursor mover: move codes,
// PS/2 arrow scancodes, decoder states and key helpers.
package cursor_move_ctrl_pkg;

    localparam logic [2:0] MV_IDLE  = 3'b000;
    localparam logic [2:0] MV_UP    = 3'b100;
    localparam logic [2:0] MV_DOWN  = 3'b011;
    localparam logic [2:0] MV_LEFT  = 3'b001;
    localparam logic [2:0] MV_RIGHT = 3'b010;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // Key vectors are {up, down, left, right}
    function automatic logic [3:0] key_onehot(input logic [7:0] code);
        logic [3:0] k;
        case (code)
            SC_UP:    k = 4'b1000;
            SC_DOWN:  k = 4'b0100;
            SC_LEFT:  k = 4'b0010;
            SC_RIGHT: k = 4'b0001;
            default:  k = 4'b0000;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] prio_pick(input logic [3:0] v);
        logic [3:0] p;
        if (v[3])      p = 4'b1000;
        else if (v[2]) p = 4'b0100;
        else if (v[1]) p = 4'b0010;
        else if (v[0]) p = 4'b0001;
        else           p = 4'b0000;
        return p;
    endfunction

endpackage

// File: rtl/cursor_move_ctrl_if.sv
// Scancode input, frame strobe and cursor outputs of the mover.
interface cursor_move_ctrl_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_tick;
    logic [2:0] move_cmd;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic [3:0] keys_held;

    modport master (
        output scan_code, scan_valid, frame_tick,
        input  move_cmd, pos_x, pos_y, keys_held
    );

    modport slave (
        input  scan_code, scan_valid, frame_tick,
        output move_cmd, pos_x, pos_y, keys_held
    );
endinterface

// File: rtl/cursor_move_ctrl_ps2_arrow_decoder.sv
// PS/2 arrow-key decoder: turns E0-extended make/break sequences
// into one-cycle make/break pulses, combinational on the key byte.
module ps2_arrow_decoder
    import cursor_move_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [3:0] make_evt,
    output logic [3:0] brk_evt
);
    logic [1:0] state, state_nx;
    logic [3:0] key;

    assign key = key_onehot(scan_code);

    always_comb begin
        state_nx = state;
        make_evt = 4'b0000;
        brk_evt  = 4'b0000;
        if (scan_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)
                        state_nx = ST_EXT;
                    else if (scan_code == SC_BRK)
                        state_nx = ST_BRK;
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK) begin
                        state_nx = ST_EXT_BRK;
                    end else if (scan_code != SC_EXT) begin
                        make_evt = key;
                        state_nx = ST_IDLE;
                    end
                end
                ST_BRK: state_nx = ST_IDLE;
                ST_EXT_BRK: begin
                    brk_evt  = key;
                    state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end
endmodule

// File: rtl/cursor_move_ctrl.sv
// Cursor move scheduler: one move per frame from pending taps or held
// keys, with press delay, typematic repeat and screen clamping.
module cursor_move_ctrl
    import cursor_move_ctrl_pkg::*;
#(
    parameter int X_INIT        = 475,
    parameter int Y_INIT        = 216,
    parameter int X_MIN         = 160,
    parameter int X_MAX         = 792,
    parameter int Y_MIN         = 49,
    parameter int Y_MAX         = 434,
    parameter int DELAY_FRAMES  = 20,
    parameter int REPEAT_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    cursor_move_ctrl_if.slave bus
);
    logic [3:0] make_evt, brk_evt;
    logic [3:0] held, held_nx;
    logic [3:0] pending, pend_nx;
    logic [3:0] last_sel, last_nx;
    logic [3:0] pend_sel, held_sel, mv_sel;
    logic [7:0] rep_cnt, rep_nx;
    logic [2:0] move_cmd, cmd_nx;
    logic [9:0] pos_x, x_nx;
    logic [8:0] pos_y, y_nx;
    logic       tick;

    ps2_arrow_decoder u_dec (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (bus.scan_code),
        .scan_valid (bus.scan_valid),
        .make_evt   (make_evt),
        .brk_evt    (brk_evt)
    );

    assign tick     = bus.frame_tick && (move_cmd == MV_IDLE);
    assign pend_sel = prio_pick(pending);
    assign held_sel = prio_pick(held);

    // last_sel remembers the direction served on the previous tick
    always_comb begin
        pend_nx = pending;
        rep_nx  = rep_cnt;
        last_nx = last_sel;
        mv_sel  = 4'b0000;
        if (tick) begin
            if (|pending) begin
                mv_sel  = pend_sel;
                pend_nx = pending & ~pend_sel;
                rep_nx  = 8'(DELAY_FRAMES - 1);
                last_nx = pend_sel;
            end else if (|held) begin
                last_nx = held_sel;
                if (held_sel != last_sel) begin
                    rep_nx = 8'(DELAY_FRAMES - 1);
                end else if (rep_cnt == 8'd0) begin
                    mv_sel = held_sel;
                    rep_nx = 8'(REPEAT_FRAMES - 1);
                end else begin
                    rep_nx = rep_cnt - 8'd1;
                end
            end else begin
                rep_nx  = 8'd0;
                last_nx = 4'b0000;
            end
        end
        pend_nx = pend_nx | (make_evt & ~held);
        held_nx = (held | make_evt) & ~brk_evt;
    end

    always_comb begin
        cmd_nx = MV_IDLE;
        x_nx   = pos_x;
        y_nx   = pos_y;
        if (mv_sel[3] && pos_y > 9'(Y_MIN)) begin
            cmd_nx = MV_UP;
            y_nx   = pos_y - 9'd1;
        end else if (mv_sel[2] && pos_y < 9'(Y_MAX)) begin
            cmd_nx = MV_DOWN;
            y_nx   = pos_y + 9'd1;
        end else if (mv_sel[1] && pos_x > 10'(X_MIN)) begin
            cmd_nx = MV_LEFT;
            x_nx   = pos_x - 10'd1;
        end else if (mv_sel[0] && pos_x < 10'(X_MAX)) begin
            cmd_nx = MV_RIGHT;
            x_nx   = pos_x + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held     <= 4'b0000;
            pending  <= 4'b0000;
            last_sel <= 4'b0000;
            rep_cnt  <= 8'd0;
            move_cmd <= MV_IDLE;
            pos_x    <= 10'(X_INIT);
            pos_y    <= 9'(Y_INIT);
        end else begin
            held     <= held_nx;
            pending  <= pend_nx;
            last_sel <= last_nx;
            rep_cnt  <= rep_nx;
            move_cmd <= cmd_nx;
            pos_x    <= x_nx;
            pos_y    <= y_nx;
        end
    end

    assign bus.move_cmd  = move_cmd;
    assign bus.pos_x     = pos_x;
    assign bus.pos_y     = pos_y;
    assign bus.keys_held = held;
endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Bench for cursor_move_ctrl: directed scenarios and random traffic
// against a frame-age reference model of the cursor scheduler.
module tb_cursor_move_ctrl;
    localparam int DELAY  = 20;
    localparam int REPEAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    cursor_move_ctrl_if bus();

    cursor_move_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: index 0..3 = up, down, left, right
    bit         m_held[4];
    bit         m_pend[4];
    int         m_cur, m_age, m_px, m_py;
    logic [2:0] m_cmd;
    bit         m_ext, m_brk;

    wire [25:0] dut_vec = {bus.move_cmd, bus.pos_x, bus.pos_y, bus.keys_held};

    function automatic logic [25:0] exp_vec();
        logic [3:0] k;
        k = {m_held[0], m_held[1], m_held[2], m_held[3]};
        return {m_cmd, 10'(m_px), 9'(m_py), k};
    endfunction

    function automatic int key_idx(input logic [7:0] c);
        case (c)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_init();
        for (int i = 0; i < 4; i++) begin
            m_held[i] = 0;
            m_pend[i] = 0;
        end
        m_cur = -1; m_age = 0;
        m_px = 475; m_py = 216;
        m_cmd = 3'b000;
        m_ext = 0; m_brk = 0;
    endtask

    task automatic model_tick();
        int d;
        bit mv;
        d = -1; mv = 0;
        for (int i = 0; i < 4; i++) if (d < 0 && m_pend[i]) d = i;
        if (d >= 0) begin
            m_pend[d] = 0; m_cur = d; m_age = 0; mv = 1;
        end else begin
            for (int i = 0; i < 4; i++) if (d < 0 && m_held[i]) d = i;
            if (d < 0) begin
                m_cur = -1;
            end else if (d != m_cur) begin
                m_cur = d; m_age = 0;
            end else begin
                m_age++;
                mv = (m_age >= DELAY) && ((m_age - DELAY) % REPEAT == 0);
            end
        end
        if (mv) begin
            case (d)
                0: if (m_py > 49)  begin m_py--; m_cmd = 3'b100; end
                1: if (m_py < 434) begin m_py++; m_cmd = 3'b011; end
                2: if (m_px > 160) begin m_px--; m_cmd = 3'b001; end
                3: if (m_px < 792) begin m_px++; m_cmd = 3'b010; end
                default: ;
            endcase
        end
    endtask

    task automatic model_byte(input logic [7:0] c);
        int k;
        k = key_idx(c);
        if (!m_ext && !m_brk) begin
            if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0) m_brk = 1;
        end else if (!m_ext && m_brk) begin
            m_brk = 0;
        end else if (m_ext && !m_brk) begin
            if (c == 8'hF0) m_brk = 1;
            else if (c != 8'hE0) begin
                if (k >= 0 && !m_held[k]) begin
                    m_held[k] = 1; m_pend[k] = 1;
                end
                m_ext = 0;
            end
        end else begin
            if (k >= 0) m_held[k] = 0;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic step(input logic [7:0] code, input bit valid, input bit tick);
        bit eff;
        bus.scan_code = code;
        bus.scan_valid = valid;
        bus.frame_tick = tick;
        eff = tick && (m_cmd == 3'b000);
        m_cmd = 3'b000;
        if (eff) model_tick();
        if (valid) model_byte(code);
        @(posedge clk);
        #1;
        bus.scan_valid = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        bus.scan_valid = 1'b0;
        bus.frame_tick = 1'b0;
        bus.scan_code = 8'h00;
        reset = 1'b0;
        model_init();
        #3;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (dut_vec !== {3'b000, 10'd475, 9'd216, 4'b0000}) begin
            errors++;
            $display("FAIL reset: got %h want %h", dut_vec,
                     {3'b000, 10'd475, 9'd216, 4'b0000});
        end
    endtask

    task automatic test_press_up();
        send(8'hE0); send(8'h75);
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if ({bus.move_cmd, bus.pos_y, bus.keys_held} !== {3'b100, 9'd215, 4'b1000}) begin
            errors++;
            $display("FAIL press_up: cmd %b y %0d held %b want 100 215 1000",
                     bus.move_cmd, bus.pos_y, bus.keys_held);
        end
        step(8'h00, 1'b0, 1'b0);
        checks++;
        if (bus.move_cmd !== 3'b000) begin
            errors++;
            $display("FAIL press_up_pulse: cmd %b want 000", bus.move_cmd);
        end
    endtask

    task automatic test_typematic();
        int moves[$];
        int want[4] = '{1, 21, 25, 29};
        int late;
        bit ok;
        do_reset();
        send(8'hE0); send(8'h75);
        for (int t = 1; t <= 30; t++) begin
            if (t % 3 == 0) begin send(8'hE0); send(8'h75); end
            step(8'h00, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL typematic t%0d: got %h want %h", t, dut_vec, exp_vec());
            end
            if (bus.move_cmd != 3'b000) moves.push_back(t);
            step(8'h00, 1'b0, 1'b0);
        end
        ok = (moves.size() == 4);
        if (ok) for (int i = 0; i < 4; i++) if (moves[i] != want[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL typematic_ticks: got %p want 1 21 25 29", moves);
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        late = 0;
        for (int t = 0; t < 10; t++) begin
            step(8'h00, 1'b0, 1'b1);
            if (bus.move_cmd != 3'b000) late++;
            step(8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (late != 0 || bus.keys_held !== 4'b0000 || bus.pos_y !== 9'd212) begin
            errors++;
            $display("FAIL typematic_release: moves %0d held %b y %0d want 0 0000 212",
                     late, bus.keys_held, bus.pos_y);
        end
    endtask

    task automatic test_tap();
        int late;
        do_reset();
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if ({bus.move_cmd, bus.pos_x, bus.keys_held} !== {3'b001, 10'd474, 4'b0000}) begin
            errors++;
            $display("FAIL tap: cmd %b x %0d held %b want 001 474 0000",
                     bus.move_cmd, bus.pos_x, bus.keys_held);
        end
        late = 0;
        for (int t = 0; t < 25; t++) begin
            step(8'h00, 1'b0, 0);
            step(8'h00, 1'b0, 1'b1);
            if (bus.move_cmd != 3'b000) late++;
        end
        checks++;
        if (late != 0 || bus.pos_x !== 10'd474) begin
            errors++;
            $display("FAIL tap_once: extra %0d x %0d want 0 474", late, bus.pos_x);
        end
    endtask

    task automatic test_two_keys();
        int rmoves[$];
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h74);
        for (int t = 1; t <= 10; t++) begin
            step(8'h00, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL two_keys t%0d: got %h want %h", t, dut_vec, exp_vec());
            end
            if (t == 1) begin
                checks++;
                if (bus.move_cmd !== 3'b100) begin
                    errors++;
                    $display("FAIL two_keys_prio: cmd %b want 100", bus.move_cmd);
                end
            end
            step(8'h00, 1'b0, 1'b0);
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        for (int t = 1; t <= 26; t++) begin
            step(8'h00, 1'b0, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fresh_right t%0d: got %h want %h", t, dut_vec, exp_vec());
            end
            if (bus.move_cmd == 3'b010) rmoves.push_back(t);
            step(8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (rmoves.size() != 2 || rmoves[0] != 21 || rmoves[1] != 25) begin
            errors++;
            $display("FAIL fresh_right_ticks: got %p want 21 25", rmoves);
        end
    endtask

    task automatic test_clamp();
        int n;
        do_reset();
        send(8'hE0); send(8'h6B);
        n = 0;
        while (m_px > 160 && n < 2000) begin
            step(8'h00, 1'b0, 1'b1);
            step(8'h00, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (bus.pos_x !== 10'd160) begin
            errors++;
            $display("FAIL clamp_reach: x %0d want 160 after %0d ticks", bus.pos_x, n);
        end
        for (int t = 0; t < 20; t++) begin
            step(8'h00, 1'b0, 1'b1);
            checks++;
            if (bus.move_cmd !== 3'b000 || bus.pos_x !== 10'd160 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL clamp_hold t%0d: cmd %b x %0d want 000 160",
                         t, bus.move_cmd, bus.pos_x);
            end
            step(8'h00, 1'b0, 1'b0);
        end
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0); send(8'h74);
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.move_cmd !== 3'b010 || bus.pos_x !== 10'd161) begin
            errors++;
            $display("FAIL clamp_right: cmd %b x %0d want 010 161", bus.move_cmd, bus.pos_x);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h75);
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.keys_held !== 4'b0000 || bus.move_cmd !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: held %b cmd %b want 0000 000",
                     bus.keys_held, bus.move_cmd);
        end
        step(8'h00, 1'b0, 1'b0);
        send(8'hE0);
        step(8'h74, 1'b1, 1'b1);
        checks++;
        if (bus.move_cmd !== 3'b000 || bus.keys_held !== 4'b0001) begin
            errors++;
            $display("FAIL same_cycle: cmd %b held %b want 000 0001",
                     bus.move_cmd, bus.keys_held);
        end
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.move_cmd !== 3'b010 || bus.pos_x !== 10'd476) begin
            errors++;
            $display("FAIL same_cycle_next: cmd %b x %0d want 010 476",
                     bus.move_cmd, bus.pos_x);
        end
    endtask

    task automatic test_random();
        logic [7:0] tbl[7] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
        logic [7:0] c;
        int idx;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            idx = int'($urandom % 7);
            c = (idx == 6) ? 8'($urandom) : tbl[idx];
            step(c, ($urandom % 3) == 0, ($urandom % 6) == 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random s%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.scan_code = 8'h00;
        bus.scan_valid = 1'b0;
        bus.frame_tick = 1'b0;
        model_init();
        @(posedge clk);
        #1;
        test_reset();
        test_press_up();
        test_typematic();
        test_tap();
        test_two_keys();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
